// File: rtl/regfile_mp_pkg.sv
// Shared constants, types and port-priority helper for the multi-port register file.
package regfile_mp_pkg;

  localparam int NR_WR_DEF  = 2;
  localparam int NR_RD_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int NR_REG_DEF = 32;
  localparam int CNT_W_DEF  = 2;
  localparam int MAX_PORTS  = 16;

  typedef logic [$clog2(NR_REG_DEF)-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0]         reg_data_t;

  // hit[i] = port i matches the address; returns a one-hot of the youngest (highest) match.
  function automatic logic [MAX_PORTS-1:0] youngest_match(input logic [MAX_PORTS-1:0] hit);
    logic [MAX_PORTS-1:0] sel;
    sel = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (hit[i]) sel = MAX_PORTS'(1) << i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: per-register in-flight counters, group issue stall,
// flush handling and a sticky underflow flag.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int NR_WR  = NR_WR_DEF,
  parameter int NR_REG = NR_REG_DEF,
  parameter int ADDR_W = $clog2(NR_REG),
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NR_WR-1:0]          wr_en,
  input  logic [NR_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NR_WR-1:0]          iss_en,
  input  logic [NR_WR*ADDR_W-1:0]   iss_addr,
  output logic [NR_REG*CNT_W-1:0]   cnt_flat,
  output logic                      iss_stall,
  output logic                      sb_err
);

  // Wide enough to hold cnt_max + NR_WR without wrapping.
  localparam int SUM_W = CNT_W + $clog2(NR_WR + 1) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [NR_REG-1:0] over;
  logic [NR_REG-1:0] under;
  logic              err_reg;

  assign iss_stall = !rst && (|over);
  assign sb_err    = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NR_REG; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        assign over[gi]              = 1'b0;
        assign under[gi]             = 1'b0;
        assign cnt_flat[CNT_W-1:0]   = '0;
      end else begin : g_live
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic [SUM_W-1:0] inc;
        logic [SUM_W-1:0] dec;
        logic [SUM_W-1:0] sum_all;
        logic [SUM_W-1:0] sum_acc;

        always_comb begin
          inc = '0;
          dec = '0;
          for (int p = 0; p < NR_WR; p++) begin
            if (iss_en[p] && iss_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(gi)) inc = inc + SUM_W'(1);
            if (wr_en[p]  && wr_addr[p*ADDR_W +: ADDR_W]  == ADDR_W'(gi)) dec = dec + SUM_W'(1);
          end
          sum_all = SUM_W'(cnt_reg) + inc;
        end

        // Only registers actually targeted by an issue can reject the group.
        assign over[gi]  = (inc != '0) && (sum_all >= dec) && ((sum_all - dec) > CNT_MAX);
        assign sum_acc   = SUM_W'(cnt_reg) + (iss_stall ? SUM_W'(0) : inc);
        assign under[gi] = sum_acc < dec;
        assign cnt_next  = under[gi] ? '0 : CNT_W'(sum_acc - dec);

        always_ff @(posedge clk) begin
          if (rst || flush) cnt_reg <= '0;
          else              cnt_reg <= cnt_next;
        end

        assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)           err_reg <= 1'b0;
    else if (|under)   err_reg <= 1'b1;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard; r0 reads as zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int NR_WR  = NR_WR_DEF,
  parameter int NR_RD  = NR_RD_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int NR_REG = NR_REG_DEF,
  parameter int ADDR_W = $clog2(NR_REG),
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_WR-1:0]          wr_en,
  input  logic [NR_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NR_WR*DATA_W-1:0]   wr_data,
  input  logic [NR_RD-1:0]          rd_en,
  input  logic [NR_RD*ADDR_W-1:0]   rd_addr,
  output logic [NR_RD*DATA_W-1:0]   rd_data,
  output logic [NR_RD-1:0]          rd_ready,
  input  logic [NR_WR-1:0]          iss_en,
  input  logic [NR_WR*ADDR_W-1:0]   iss_addr,
  output logic                      iss_stall,
  input  logic                      flush,
  output logic                      sb_err,
  output logic [NR_REG*DATA_W-1:0]  debug_reg
);

  logic [NR_REG*DATA_W-1:0] reg_flat;
  logic [NR_REG*CNT_W-1:0]  cnt_flat;

  assign debug_reg = reg_flat;

  regfile_mp_sb #(
    .NR_WR(NR_WR), .NR_REG(NR_REG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) u_sb (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .cnt_flat(cnt_flat), .iss_stall(iss_stall), .sb_err(sb_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NR_REG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_flat[DATA_W-1:0] = '0;
      end else begin : g_flop
        logic [NR_WR-1:0]  hit;
        logic [NR_WR-1:0]  sel;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] q_reg;

        always_comb begin
          hit   = '0;
          wdata = '0;
          for (int p = 0; p < NR_WR; p++)
            hit[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(gi));
          sel = NR_WR'(youngest_match(MAX_PORTS'(hit)));
          for (int p = 0; p < NR_WR; p++)
            if (sel[p]) wdata = wr_data[p*DATA_W +: DATA_W];
        end

        always_ff @(posedge clk) begin
          if (rst)       q_reg <= '0;
          else if (|hit) q_reg <= wdata;
        end

        assign reg_flat[gi*DATA_W +: DATA_W] = q_reg;
      end
    end

    for (gi = 0; gi < NR_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  cnt;
      logic              ready;
`ifdef REGFILE_MP_BYPASS_EN
      logic [NR_WR-1:0]  hit;
      logic [NR_WR-1:0]  sel;
`endif

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data = '0;
        cnt  = '0;
        for (int r = 0; r < NR_REG; r++) begin
          if (addr == ADDR_W'(r)) begin
            data = reg_flat[r*DATA_W +: DATA_W];
            cnt  = cnt_flat[r*CNT_W +: CNT_W];
          end
        end
        ready = (cnt == '0);
`ifdef REGFILE_MP_BYPASS_EN
        hit = '0;
        for (int p = 0; p < NR_WR; p++)
          hit[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr);
        sel = NR_WR'(youngest_match(MAX_PORTS'(hit)));
        // The last outstanding writer retiring now makes the operand usable this cycle.
        for (int p = 0; p < NR_WR; p++) begin
          if (sel[p]) begin
            data = wr_data[p*DATA_W +: DATA_W];
            if (cnt == CNT_W'(1)) ready = 1'b1;
          end
        end
`endif
        if (rst || !rd_en[gi] || addr == '0) begin
          data  = '0;
          ready = 1'b1;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_ready[gi]                 = ready;
    end
  endgenerate

endmodule
